// File: rtl/punchout_pkg.sv
// Shared encodings and constants for the punch-out game datapath.
package punchout_pkg;

   localparam logic [1:0] LANE_NONE  = 2'b00;
   localparam logic [1:0] LANE_LEFT  = 2'b01;
   localparam logic [1:0] LANE_MID   = 2'b10;
   localparam logic [1:0] LANE_RIGHT = 2'b11;

   localparam int ENEMY_HP_W  = 4;
   localparam int PLAYER_HP_W = 3;

   localparam int STRIKE_CALM = 4;
   localparam int STRIKE_AGGR = 2;

   typedef enum logic [1:0] {
      ST_PLAY      = 2'd0,
      ST_ENEMY_KO  = 2'd1,
      ST_PLAYER_KO = 2'd2
   } state_t;

endpackage

// File: rtl/rate_tick.sv
// Programmable-rate pulse generator: one registered tick every TICK_DIV
// (or TICK_DIV/2 when half is set) enabled cycles.
module rate_tick #(
   parameter int TICK_DIV = 12500000
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic half,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);

   logic [CW-1:0] count;
   logic [CW-1:0] limit_m1;

   assign limit_m1 = half ? CW'(TICK_DIV / 2 - 1) : CW'(TICK_DIV - 1);

   // A count already past a freshly lowered limit restarts without ticking.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
         tick  <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (enable) begin
            if (count >= limit_m1) begin
               count <= '0;
               tick  <= (count == limit_m1);
            end else begin
               count <= count + CW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/combat_resolver.sv
// Enemy pacing, punch/strike resolution, health tracking and match result.
import punchout_pkg::*;

module combat_resolver #(
   parameter int         TICK_DIV      = 12500000,
   parameter int         ENEMY_MAX_HP  = 10,
   parameter int         PLAYER_MAX_HP = 4,
   parameter int         COOLDOWN      = 6250000,
   parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   punch,
   input  logic [1:0]             player_x,
   input  logic [1:0]             enemy_x,
   input  logic                   enemy_speed,
   input  logic                   enemy_attack,
   input  logic                   enemy_dead,
   output logic [ENEMY_HP_W-1:0]  enemy_health,
   output logic [PLAYER_HP_W-1:0] player_health,
   output logic                   move_tick,
   output logic                   go,
   output logic                   enemy_hit,
   output logic                   player_hit,
   output logic                   game_over,
   output logic                   player_won
);

   localparam int CD_W = $clog2(COOLDOWN + 1);

   state_t          state, state_next;
   logic [7:0]      lfsr;
   logic [2:0]      strikes, strike_inc, thresh;
   logic [CD_W-1:0] cooldown;
   logic            punch_q, tick_en, hit_lane, punch_ok, strike_due;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= ST_PLAY;
      else       state <= state_next;
   end

   // Enemy knockout takes priority when both sides fall together.
   always_comb begin
      state_next = state;
      if (state == ST_PLAY) begin
         if (enemy_health == '0 || enemy_dead) state_next = ST_ENEMY_KO;
         else if (player_health == '0)         state_next = ST_PLAYER_KO;
      end
   end

   // Ticking stops on the cycle the match ends, so no pulse leaks into KO.
   assign tick_en    = (state == ST_PLAY) && (state_next == ST_PLAY);
   assign hit_lane   = (enemy_x == player_x) && (enemy_x != LANE_NONE);
   assign punch_ok   = punch && !punch_q && (cooldown == '0) && (state == ST_PLAY);
   assign thresh     = enemy_attack ? 3'(STRIKE_AGGR) : 3'(STRIKE_CALM);
   assign strike_inc = strikes + 3'd1;
   assign strike_due = move_tick && (strike_inc >= thresh);
   assign go         = lfsr[0];

   rate_tick #(.TICK_DIV(TICK_DIV)) u_rate_tick (
      .clock  (clock),
      .reset  (reset),
      .enable (tick_en),
      .half   (enemy_speed),
      .tick   (move_tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         enemy_health  <= ENEMY_HP_W'(ENEMY_MAX_HP);
         player_health <= PLAYER_HP_W'(PLAYER_MAX_HP);
         lfsr          <= LFSR_SEED;
         strikes       <= '0;
         cooldown      <= '0;
         punch_q       <= 1'b0;
         enemy_hit     <= 1'b0;
         player_hit    <= 1'b0;
         game_over     <= 1'b0;
         player_won    <= 1'b0;
      end else begin
         punch_q    <= punch;
         enemy_hit  <= 1'b0;
         player_hit <= 1'b0;
         game_over  <= (state_next != ST_PLAY);
         player_won <= (state_next == ST_ENEMY_KO);
         if (move_tick) begin
            lfsr    <= {lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3], lfsr[7:1]};
            strikes <= strike_due ? 3'd0 : strike_inc;
         end
         if (punch_ok)              cooldown <= CD_W'(COOLDOWN);
         else if (cooldown != '0)   cooldown <= cooldown - CD_W'(1);
         if (state == ST_PLAY) begin
            if (punch_ok && hit_lane) begin
               enemy_hit <= 1'b1;
               if (enemy_health != '0) enemy_health <= enemy_health - ENEMY_HP_W'(1);
            end
            if (strike_due && hit_lane) begin
               player_hit <= 1'b1;
               if (player_health != '0) player_health <= player_health - PLAYER_HP_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_combat_resolver.sv
// Testbench for combat_resolver: vector table, directed corner sequences and
// randomized play against a behavioural game model.
module tb_combat_resolver;

   localparam int         TD   = 8;
   localparam int         EHP  = 10;
   localparam int         PHP  = 4;
   localparam int         CD   = 5;
   localparam logic [7:0] SEED = 8'hA5;

   logic       clock = 1'b0, reset = 1'b1, punch = 1'b0;
   logic       enemy_speed = 1'b0, enemy_attack = 1'b0, enemy_dead = 1'b0;
   logic [1:0] player_x = 2'b00, enemy_x = 2'b00;
   logic [3:0] enemy_health;
   logic [2:0] player_health;
   logic       move_tick, go, enemy_hit, player_hit, game_over, player_won;

   int vectors = 0;
   int miscompares = 0;

   combat_resolver #(
      .TICK_DIV(TD), .ENEMY_MAX_HP(EHP), .PLAYER_MAX_HP(PHP),
      .COOLDOWN(CD), .LFSR_SEED(SEED)
   ) dut (
      .clock(clock), .reset(reset), .punch(punch),
      .player_x(player_x), .enemy_x(enemy_x),
      .enemy_speed(enemy_speed), .enemy_attack(enemy_attack), .enemy_dead(enemy_dead),
      .enemy_health(enemy_health), .player_health(player_health),
      .move_tick(move_tick), .go(go), .enemy_hit(enemy_hit), .player_hit(player_hit),
      .game_over(game_over), .player_won(player_won)
   );

   always #5 clock = ~clock;

   initial begin
      #1ms;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   // Behavioural game model
   int         m_eh, m_ph, m_since_tick, m_moves, m_cool;
   bit         m_tick, m_prev_punch, m_ehit, m_phit, m_over, m_won;
   logic [7:0] m_lfsr;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[7] ^ v[5] ^ v[4] ^ v[3], v[7:1]};
   endfunction

   task automatic model_reset();
      m_eh = EHP; m_ph = PHP; m_since_tick = 0; m_moves = 0; m_cool = 0;
      m_tick = 0; m_prev_punch = 0; m_ehit = 0; m_phit = 0;
      m_over = 0; m_won = 0; m_lfsr = SEED;
   endtask

   task automatic model_step();
      bit playing      = !m_over;
      bit enemy_down   = playing && (m_eh == 0 || enemy_dead);
      bit player_down  = playing && !enemy_down && (m_ph == 0);
      bit pacing       = playing && !enemy_down && !player_down;
      int period       = enemy_speed ? TD / 2 : TD;
      bit same_lane    = (player_x == enemy_x) && (enemy_x != 2'b00);
      bit landed       = punch && !m_prev_punch && (m_cool == 0) && playing;
      bit strike       = 0;
      bit next_tick    = pacing && (m_since_tick == period - 1);
      if (m_tick) begin
         m_lfsr = lfsr_next(m_lfsr);
         m_moves++;
         if (m_moves >= (enemy_attack ? 2 : 4)) begin
            m_moves = 0;
            strike = 1;
         end
      end
      if (pacing) m_since_tick = (m_since_tick >= period - 1) ? 0 : m_since_tick + 1;
      m_cool = landed ? CD : (m_cool > 0 ? m_cool - 1 : 0);
      m_ehit = landed && same_lane;
      m_phit = strike && same_lane && playing;
      if (m_ehit && m_eh > 0) m_eh--;
      if (m_phit && m_ph > 0) m_ph--;
      m_prev_punch = punch;
      m_tick = next_tick;
      if (enemy_down) begin
         m_over = 1; m_won = 1;
      end else if (player_down) begin
         m_over = 1;
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("enemy_health", int'(enemy_health), m_eh);
      check("player_health", int'(player_health), m_ph);
      check("move_tick", int'(move_tick), int'(m_tick));
      check("go", int'(go), int'(m_lfsr[0]));
      check("enemy_hit", int'(enemy_hit), int'(m_ehit));
      check("player_hit", int'(player_hit), int'(m_phit));
      check("game_over", int'(game_over), int'(m_over));
      check("player_won", int'(player_won), int'(m_won));
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
      if (!reset) model_step();
      compare_all();
   endtask

   task automatic wait_tick(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!move_tick && n < 40);
      if (!move_tick) check("tick_timeout", 0, 1);
   endtask

   // Reset asserted between edges; outputs must restore without a clock edge.
   task automatic async_reset();
      @(posedge clock);
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_enemy_health", int'(enemy_health), EHP);
      check("rst_player_health", int'(player_health), PHP);
      check("rst_game_over", int'(game_over), 0);
      check("rst_player_won", int'(player_won), 0);
      check("rst_go", int'(go), int'(SEED[0]));
      check("rst_move_tick", int'(move_tick), 0);
      punch = 0; enemy_dead = 0; enemy_speed = 0; enemy_attack = 0;
      player_x = 2'b00; enemy_x = 2'b00;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      bit         p;
      logic [1:0] px, ex;
      bit         spd, atk, dead;
      int         cycles;
      int         eh, ph;
      bit         over, won;
   } row_t;

   row_t rows[$];

   function automatic row_t mk(bit p, logic [1:0] px, logic [1:0] ex, bit spd, bit atk,
                               bit dead, int cycles, int eh, int ph, bit over, bit won);
      row_t r;
      r.p = p; r.px = px; r.ex = ex; r.spd = spd; r.atk = atk; r.dead = dead;
      r.cycles = cycles; r.eh = eh; r.ph = ph; r.over = over; r.won = won;
      return r;
   endfunction

   initial begin
      int n;
      int e;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("init_enemy_health", int'(enemy_health), EHP);
      check("init_player_health", int'(player_health), PHP);
      check("init_go", int'(go), int'(SEED[0]));
      check("init_game_over", int'(game_over), 0);
      reset = 1'b0;

      // Tick pacing: first pulse 8 edges after release, then every 8, then every 4.
      wait_tick(n); check("tick_first", n, 8);
      wait_tick(n); check("tick_calm", n, 8);
      enemy_speed = 1'b1;
      wait_tick(n); check("tick_aggr1", n, 4);
      wait_tick(n); check("tick_aggr2", n, 4);

      // Vector table; edge numbers below count from reset release.
      rows.push_back(mk(0, 2'b10, 2'b10, 0, 0, 0,  2, 10, 4, 0, 0));
      rows.push_back(mk(1, 2'b10, 2'b10, 0, 0, 0,  1,  9, 4, 0, 0));
      rows.push_back(mk(0, 2'b10, 2'b10, 0, 0, 0,  2,  9, 4, 0, 0));
      rows.push_back(mk(1, 2'b10, 2'b10, 0, 0, 0,  1,  9, 4, 0, 0));
      rows.push_back(mk(1, 2'b10, 2'b10, 0, 0, 0, 20,  9, 4, 0, 0));
      rows.push_back(mk(0, 2'b00, 2'b10, 0, 0, 0, 12,  9, 4, 0, 0));
      rows.push_back(mk(0, 2'b01, 2'b01, 0, 1, 0, 16,  9, 3, 0, 0));
      rows.push_back(mk(0, 2'b01, 2'b01, 0, 0, 0, 32,  9, 2, 0, 0));
      for (int k = 1; k <= 9; k++) begin
         e = 86 + 6 * (k - 1) + 1;
         rows.push_back(mk(1, 2'b11, 2'b11, 0, 0, 0, 1, 9 - k, (e >= 113) ? 1 : 2, 0, 0));
         rows.push_back(mk(0, 2'b11, 2'b11, 0, 0, 0, 5, 9 - k, (e + 5 >= 113) ? 1 : 2,
                           k == 9, k == 9));
      end
      rows.push_back(mk(1, 2'b11, 2'b11, 0, 0, 0,  1, 0, 1, 1, 1));
      rows.push_back(mk(1, 2'b01, 2'b01, 1, 1, 0, 40, 0, 1, 1, 1));

      async_reset();
      foreach (rows[i]) begin
         punch = rows[i].p; player_x = rows[i].px; enemy_x = rows[i].ex;
         enemy_speed = rows[i].spd; enemy_attack = rows[i].atk; enemy_dead = rows[i].dead;
         repeat (rows[i].cycles) cyc();
         check($sformatf("row%0d_enemy_health", i), int'(enemy_health), rows[i].eh);
         check($sformatf("row%0d_player_health", i), int'(player_health), rows[i].ph);
         check($sformatf("row%0d_game_over", i), int'(game_over), int'(rows[i].over));
         check($sformatf("row%0d_player_won", i), int'(player_won), int'(rows[i].won));
      end

      // Punch hit and strike landing together at 1/1 health: enemy KO wins.
      async_reset();
      player_x = 2'b10; enemy_x = 2'b10; enemy_attack = 1'b1;
      for (int k = 0; k < 9; k++) begin
         punch = 1'b1; cyc();
         punch = 1'b0; repeat (5) cyc();
      end
      check("dual_pre_enemy", int'(enemy_health), 1);
      check("dual_pre_player", int'(player_health), 1);
      wait_tick(n); check("dual_tick_a", n, 2);
      wait_tick(n); check("dual_tick_b", n, 8);
      punch = 1'b1; cyc();
      check("dual_enemy_zero", int'(enemy_health), 0);
      check("dual_player_zero", int'(player_health), 0);
      check("dual_over_late", int'(game_over), 0);
      punch = 1'b0; cyc();
      check("dual_game_over", int'(game_over), 1);
      check("dual_player_won", int'(player_won), 1);

      // Player knocked out, then reset mid-cycle.
      async_reset();
      player_x = 2'b01; enemy_x = 2'b01; enemy_attack = 1'b1;
      repeat (70) cyc();
      check("pko_player_health", int'(player_health), 0);
      check("pko_game_over", int'(game_over), 1);
      check("pko_player_won", int'(player_won), 0);
      async_reset();
      wait_tick(n); check("pko_resume_tick", n, 8);

      // Randomized play against the model.
      for (int ep = 0; ep < 15; ep++) begin
         async_reset();
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 2) == 0) punch = ~punch;
            if ($urandom_range(0, 5) == 0) player_x = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0)
               enemy_x = ($urandom_range(0, 1) == 0) ? player_x : 2'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0) enemy_speed = ~enemy_speed;
            if ($urandom_range(0, 30) == 0) enemy_attack = ~enemy_attack;
            enemy_dead = ($urandom_range(0, 400) == 0);
            cyc();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/combat_resolver.md
Name: combat_resolver

Overview:
Opponent-facing half of the enemy interface. It consumes the enemy FSM's lane, speed, attack and dead outputs and produces the signals that FSM consumes: the current enemy health, a paced move pulse and a pseudo-random direction bit. It also resolves player punches and enemy strikes against lane positions, tracks player health, and declares the match result for the VGA/score logic.

Parameters:
TICK_DIV, 12500000, clock cycles per enemy move at calm speed (4 Hz at 50 MHz); aggressive speed uses TICK_DIV/2; must be >= 4 and even.
ENEMY_MAX_HP, 10, enemy health after reset (1..15).
PLAYER_MAX_HP, 4, player health after reset (1..7).
COOLDOWN, 6250000, cycles after any accepted punch during which further punches are ignored (>= 1).
LFSR_SEED, 8'hA5, LFSR value after reset (non-zero).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
punch  in  1  player punch, debounced level; a rising edge is a punch request
player_x  in  2  player lane: 01 left, 10 middle, 11 right, 00 none (dodging)
enemy_x  in  2  enemy lane, same encoding
enemy_speed  in  1  0 calm, 1 aggressive pace
enemy_attack  in  1  0 strike every 4 moves, 1 strike every 2 moves
enemy_dead  in  1  enemy FSM in its dead state
enemy_health  out  4  enemy health
player_health  out  3  player health
move_tick  out  1  one-cycle pulse that advances the enemy FSM
go  out  1  direction bit for the enemy FSM (LFSR bit 0)
enemy_hit  out  1  one-cycle pulse when a punch lands
player_hit  out  1  one-cycle pulse when an enemy strike lands
game_over  out  1  match finished
player_won  out  1  enemy knocked out

Behaviour:
- Reset (asynchronous): enemy_health=ENEMY_MAX_HP; player_health=PLAYER_MAX_HP; tick counter, move counter and cooldown at 0; LFSR=LFSR_SEED, so go=LFSR_SEED[0]; all pulse outputs 0; FSM in PLAY; game_over=0; player_won=0. Reset asserted mid-match restores all of these immediately.
- Tick generator: counter increments each cycle in PLAY. move_tick is high for exactly the cycle in which the counter equals LIMIT-1, and the counter returns to 0 on that cycle. LIMIT is TICK_DIV when enemy_speed=0 and TICK_DIV/2 when enemy_speed=1, sampled every cycle. If the limit drops below the current count, the counter restarts at 0 on the next cycle and no tick is issued for that cycle.
- LFSR: 8-bit Fibonacci LFSR, taps 8,6,5,4, shifting toward bit 0. It advances once per move_tick and go is its registered bit 0.
- Strike counter: increments on each move_tick. THRESH is 4 when enemy_attack=0 and 2 when enemy_attack=1. On a move_tick that brings the count to THRESH or more:
  - the count clears;
  - if enemy_x == player_x and enemy_x != 00: player_health decrements, saturating at 0, and player_hit pulses in the following cycle.
  - A dodge (player_x=00) always avoids the strike.
- Punch: a registered edge detector accepts a punch when punch is 1 now and was 0 last cycle, cooldown==0 and the FSM is in PLAY.
  - Every accepted punch loads cooldown with COOLDOWN; cooldown decrements to 0 each cycle.
  - If enemy_x == player_x and enemy_x != 00, enemy_health decrements (saturating at 0) and enemy_hit pulses in the following cycle.
  - A held punch counts once. An edge during cooldown is dropped, not queued.
- Simultaneous punch hit and strike: both health updates apply in the same cycle.
- FSM, with states PLAY, ENEMY_KO and PLAYER_KO:
  - PLAY to ENEMY_KO when enemy_health==0 or enemy_dead==1.
  - PLAY to PLAYER_KO when player_health==0.
  - If both conditions are true in the same cycle, ENEMY_KO wins.
  - Both KO states are sticky until reset.
  - In either KO state, move_tick, enemy_hit and player_hit stay 0 and both health values freeze.
  - game_over=1 in either KO state; player_won=1 only in ENEMY_KO. Both are registered, so they assert 1 cycle after the health reaches 0.
- All outputs are registered.

Decomposition:
- Package punchout_pkg holds:
  - lane encodings LANE_NONE, LANE_LEFT, LANE_MID, LANE_RIGHT;
  - the combat_resolver FSM state encoding;
  - the health widths (4 and 3);
  - the strike thresholds (4 and 2).
- Sub-module rate_tick: the tick generator (inputs clock, reset, enable, half; output tick), reusable for the animation pacing.

Test Plan:
1. Run with TICK_DIV=8 and enemy_speed=0 -> move_tick pulses every 8 cycles, with the first pulse in cycle 8 after reset release. Switch enemy_speed to 1 -> pulses every 4 cycles. go follows the LFSR sequence starting from 8'hA5.
2. Set player_x=enemy_x=10 with cooldown 0 and raise punch -> enemy_health goes 10 to 9 and one enemy_hit pulse follows. A second edge within COOLDOWN cycles leaves health at 9. Hold punch high for 20 cycles -> only one decrement.
3. Set enemy_attack=0, player_x=enemy_x=01 -> player_health decrements on the 4th move_tick only. With enemy_attack=1 -> it decrements every 2nd tick. With player_x=00 -> no decrement.
4. Land 10 punches -> enemy_health=0, then 1 cycle later game_over=1 and player_won=1. Further ticks, punches and strikes change nothing.
5. Set player_health=1 and enemy_health=1, then make a punch hit and a strike land in the same cycle -> both reach 0, the FSM enters ENEMY_KO and player_won=1.
6. Assert reset asynchronously (between clock edges) in PLAYER_KO -> outputs return to 10/4/0 immediately, and play resumes after release.
